// File: rtl/seq_muldiv_unit.sv
// seq_muldiv_unit: iterative signed multiply / divide, one bit per cycle.
// Shift-add MUL and restoring DIV share one magnitude work register pair.
module seq_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Start,
    input  logic             Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivByZero
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CW = $clog2(WIDTH);

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic               op_q;
    logic               neg_q;
    logic               sign_a_q;
    logic               bzero_q;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   work_hi;
    logic [WIDTH-1:0]   work_lo;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               dbz_q;

    logic               accept;
    logic               last;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   nx_hi;
    logic [WIDTH-1:0]   nx_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign accept = Start && (state == IDLE || state == DONE);
    assign last   = (count == CW'(WIDTH - 1));

    // MUL: work_hi = partial product, work_lo = multiplier shifting out.
    // DIV: work_hi = partial remainder, work_lo = dividend in / quotient out.
    always_comb begin
        mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {work_hi, work_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ok    = ~div_diff[WIDTH];
        if (op_q) begin
            nx_hi = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            nx_lo = {work_lo[WIDTH-2:0], div_ok};
        end else begin
            nx_hi = mul_sum[WIDTH:1];
            nx_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        end
        prod = neg_q ? -{nx_hi, nx_lo} : {nx_hi, nx_lo};
        if (op_q) begin
            fin_hi = sign_a_q ? -nx_hi : nx_hi;
            fin_lo = bzero_q ? '1 : (neg_q ? -nx_lo : nx_lo);
        end else begin
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state    <= IDLE;
            count    <= '0;
            op_q     <= 1'b0;
            neg_q    <= 1'b0;
            sign_a_q <= 1'b0;
            bzero_q  <= 1'b0;
            opnd     <= '0;
            work_hi  <= '0;
            work_lo  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state    <= RUN;
                        count    <= '0;
                        op_q     <= Op;
                        neg_q    <= A[WIDTH-1] ^ B[WIDTH-1];
                        sign_a_q <= A[WIDTH-1];
                        bzero_q  <= (B == '0);
                        opnd     <= Op ? magnitude(B) : magnitude(A);
                        work_hi  <= '0;
                        work_lo  <= Op ? magnitude(A) : magnitude(B);
                        hi_q     <= '0;
                        lo_q     <= '0;
                        dbz_q    <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    work_hi <= nx_hi;
                    work_lo <= nx_lo;
                    count   <= count + CW'(1);
                    if (last) begin
                        state <= DONE;
                        hi_q  <= fin_hi;
                        lo_q  <= fin_lo;
                        dbz_q <= op_q & bzero_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy      = (state == RUN);
    assign Done      = (state == DONE);
    assign Hi        = hi_q;
    assign Lo        = lo_q;
    assign DivByZero = dbz_q;

endmodule
